uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_arbiter_rr.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the arbitrated 8N1 UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam int   DEFAULT_WIDTH        = 8;
  localparam int   DEFAULT_CLKS_PER_BIT = 868;
  localparam int   FRAME_BITS           = DEFAULT_WIDTH + 2;
  localparam logic TX_IDLE              = 1'b1;

  function automatic int frame_bits(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin search starting one past ptr; one-hot grant plus encoded index.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  always_comb begin
    logic            found;
    int unsigned     cand;
    logic [IW-1:0]   cand_idx;
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand     = (32'(ptr) + off) % NUM_REQ;
      cand_idx = IW'(cand);
      if (en && !found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shared UART transmitter: accepts one byte at a time from
// NUM_REQ producers and serialises it as start + WIDTH data (LSB first) + stop.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [XW-1:0]     bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     ptr_q, ptr_d;

  logic              baud_end;
  logic              arb_en;
  logic              accept;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]     arb_idx;

  assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));
  // Arbitration is also open in the last stop-bit cycle so that the next
  // frame's start bit follows the stop bit with no idle gap.
  assign arb_en   = !reset && ((state_q == IDLE) || (state_q == STOP && baud_end));
  assign accept   = |arb_grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: baud_d = '0;
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q == XW'(WIDTH - 1)) begin
            state_d = STOP;
            tx_d    = TX_IDLE;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_d[0];
          end
        end
      end
      STOP: begin
        done_d = (baud_q == BW'(CLKS_PER_BIT - 2));
        if (baud_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      shift_d = req_data[arb_idx*WIDTH +: WIDTH];
      grant_d = arb_idx;
      ptr_d   = arb_idx;
      baud_d  = '0;
      bit_d   = '0;
      busy_d  = 1'b1;
      tx_d    = 1'b0;
      state_d = START;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= TX_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      grant_q <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign req_ready  = arb_grant;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench: a frame-level model predicts handshakes and
// expected frames; a tx-line monitor decodes each frame and compares.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int C = 4;
  localparam int FRAME = 10 * C;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic             tx;
  logic             busy;
  logic [1:0]       grant_id;
  logic             frame_done;

  uart_tx_arbiter #(.NUM_REQ(N), .WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx         (tx),
    .busy       (busy),
    .grant_id   (grant_id),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         errors = 0;

  logic       vld[N];
  logic [7:0] dat[N];
  bit         refill[N];
  int         m_ptr = N - 1;
  int         m_free = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict who (if anyone) is accepted.
  task automatic step(input bit rst);
    logic [N-1:0] exp_ready;
    int           acc;
    @(negedge clk);
    reset = rst;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = vld[i];
      req_data[i*W +: W] = dat[i];
    end
    exp_ready = '0;
    acc = -1;
    if (rst) begin
      m_ptr  = N - 1;
      m_free = 0;
      expq.delete();
    end else begin
      if (m_free > 0) m_free--;
      if (m_free == 0) begin
        for (int off = 1; off <= N; off++) begin
          int i;
          i = (m_ptr + off) % N;
          if (acc < 0 && vld[i]) acc = i;
        end
      end
      if (acc >= 0) exp_ready[acc] = 1'b1;
    end
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (rst)
      check("reset_state", {27'd0, tx, busy, frame_done, grant_id}, {27'd0, 1'b1, 1'b0, 1'b0, 2'd0});
    if (acc >= 0) begin
      expq.push_back('{id: acc, data: dat[acc]});
      m_ptr  = acc;
      m_free = FRAME;
    end
    @(posedge clk);
    #1;
    if (acc >= 0) begin
      if (refill[acc]) dat[acc] = 8'($urandom);
      else vld[acc] = 1'b0;
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      vld[i]    = 1'b0;
      refill[i] = 1'b0;
      dat[i]    = 8'($urandom);
    end
  endtask

  // Monitor: decode every frame on tx with exact bit timing.
  initial begin
    exp_t       e;
    int         bad_bits;
    int         bad_done;
    bit         aborted;
    int         b;
    logic       want;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && tx === 1'b0) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got start bit expected idle at %0t", $time);
          repeat (FRAME - 1) @(negedge clk);
        end else begin
          e = expq.pop_front();
          check("grant_id", 32'(grant_id), 32'(e.id));
          bad_bits = 0;
          bad_done = 0;
          aborted  = 1'b0;
          for (int c = 0; c < FRAME; c++) begin
            if (c > 0) begin
              @(negedge clk);
              #2;
            end
            if (reset) begin
              aborted = 1'b1;
              break;
            end
            b = c / C;
            if (b == 0) want = 1'b0;
            else if (b <= W) want = e.data[b-1];
            else want = 1'b1;
            if (tx !== want || busy !== 1'b1) bad_bits++;
            if (frame_done !== (c == FRAME - 1)) bad_done++;
          end
          if (!aborted) begin
            check("frame_bits", 32'(bad_bits), 32'd0);
            check("frame_done", 32'(bad_done), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    clear_all();

    // Reset with random request activity
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) vld[i] = 1'($urandom);
      step(1'b1);
    end
    clear_all();
    step(1'b0);

    // Single frame from requester 1
    vld[1] = 1'b1;
    dat[1] = 8'hA5;
    repeat (45) step(1'b0);

    // All four contending, held after each handshake
    step(1'b1);
    for (int i = 0; i < N; i++) begin
      vld[i]    = 1'b1;
      dat[i]    = 8'(8'h10 + i * 8'h21);
      refill[i] = 1'b1;
    end
    repeat (170) step(1'b0);
    for (int i = 0; i < N; i++) refill[i] = 1'b0;
    repeat (170) step(1'b0);

    // Two persistent requesters alternate
    clear_all();
    step(1'b1);
    vld[0] = 1'b1; refill[0] = 1'b1;
    vld[2] = 1'b1; refill[2] = 1'b1;
    repeat (170) step(1'b0);
    refill[0] = 1'b0;
    refill[2] = 1'b0;
    repeat (90) step(1'b0);

    // Reset during data bit 3, then req0 must win over req3
    clear_all();
    step(1'b1);
    vld[1] = 1'b1;
    step(1'b0);
    repeat (17) step(1'b0);
    step(1'b1);
    step(1'b1);
    vld[0] = 1'b1;
    vld[3] = 1'b1;
    repeat (90) step(1'b0);

    // Short-lived request from 3 while busy is never accepted
    clear_all();
    vld[1] = 1'b1;
    step(1'b0);
    repeat (3) step(1'b0);
    vld[3] = 1'b1;
    repeat (5) step(1'b0);
    vld[3] = 1'b0;
    vld[2] = 1'b1;
    repeat (90) step(1'b0);

    repeat (5) step(1'b0);
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
